// File: rtl/fv_mem_cntl_pkg.sv
// Shared constants and record types for the feature-vector memory controller
// and the blocks that talk to it.
package fv_mem_cntl_pkg;

  localparam int NUM_EDGE_PE = 4;
  localparam int FV_LINE_W   = 128;
  localparam int FV_DESC_W   = 12;
  localparam int EDGE_TW     = (NUM_EDGE_PE > 1) ? $clog2(NUM_EDGE_PE) : 1;

  // Descriptor as queued in the FV FIFO: [11:4] base line, [3:0] lines minus one.
  typedef struct packed {
    logic [FV_DESC_W-1:0] fv_addr;
    logic [EDGE_TW-1:0]   pe_tag;
    logic                 valid;
  } fv_desc_t;

  typedef struct packed {
    logic                 valid;
    logic [EDGE_TW-1:0]   tag;
    logic                 last;
    logic [FV_LINE_W-1:0] data;
  } pe_out_t;

endpackage

// File: rtl/fv_mem_cntl_if.sv
// FIFO, SRAM and PE-side signals of the FV memory controller in one bundle.
// Handshake: a beat moves on a rising clk edge where pe_valid and pe_ready[pe_tag] are both 1; pe_valid/pe_data/pe_tag/pe_last hold until then.
interface fv_mem_cntl_if
  import fv_mem_cntl_pkg::*;
#(
  parameter int NUM_PE = NUM_EDGE_PE,
  parameter int FV_W   = FV_LINE_W,
  parameter int AW     = 8
) ();

  localparam int TW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic                 fifo_empty;
  logic                 fifo_valid;
  logic [FV_DESC_W-1:0] fifo_fv_addr;
  logic [TW-1:0]        fifo_pe_tag;
  logic                 fifo_rinc;

  logic                 sram_cen;
  logic [AW-1:0]        sram_a;
  logic [FV_W-1:0]      sram_d;

  logic [NUM_PE-1:0]    pe_ready;
  logic                 pe_valid;
  logic [FV_W-1:0]      pe_data;
  logic [TW-1:0]        pe_tag;
  logic                 pe_last;

  logic                 busy;

  // Controller side.
  modport master (
    input  fifo_empty, fifo_valid, fifo_fv_addr, fifo_pe_tag, sram_d, pe_ready,
    output fifo_rinc, sram_cen, sram_a, pe_valid, pe_data, pe_tag, pe_last, busy
  );

  // FIFO / SRAM / PE side.
  modport slave (
    output fifo_empty, fifo_valid, fifo_fv_addr, fifo_pe_tag, sram_d, pe_ready,
    input  fifo_rinc, sram_cen, sram_a, pe_valid, pe_data, pe_tag, pe_last, busy
  );

endinterface

// File: rtl/fv_mem_cntl.sv
// Pops FV descriptors, reads their SRAM lines one at a time and streams each
// line to the tagged edge PE with a held valid/ready beat.
module fv_mem_cntl
  import fv_mem_cntl_pkg::*;
#(
  parameter int NUM_PE = NUM_EDGE_PE,
  parameter int FV_W   = FV_LINE_W,
  parameter int AW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  fv_mem_cntl_if.master bus,
  output logic [2:0]    dbg_state_o
);

  localparam int TW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_CAPT = 3'd2,
    S_RD   = 3'd3,
    S_RSP  = 3'd4,
    S_HOLD = 3'd5
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   base_q;
  logic [3:0]      len_q;
  logic [3:0]      cnt_q;
  logic [TW-1:0]   tag_q;

  logic            fifo_rinc_q;
  logic            sram_cen_q;
  logic [AW-1:0]   sram_a_q;
  logic            pe_valid_q;
  logic [FV_W-1:0] pe_data_q;
  logic [TW-1:0]   pe_tag_q;
  logic            pe_last_q;
  logic            busy_q;

  logic            hs;
  logic [3:0]      cnt_nxt;
  logic [AW-1:0]   desc_base;

  assign hs        = pe_valid_q & bus.pe_ready[tag_q];
  assign cnt_nxt   = cnt_q + 4'd1;
  assign desc_base = AW'(bus.fifo_fv_addr[11:4]);

  // Outputs are registered alongside the state so each one is a plain flop;
  // address arithmetic is AW bits wide so the last line wraps to line 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      fifo_rinc_q <= 1'b0;
      sram_cen_q  <= 1'b0;
      sram_a_q    <= '0;
      pe_valid_q  <= 1'b0;
      pe_data_q   <= '0;
      pe_tag_q    <= '0;
      pe_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fifo_rinc_q <= 1'b0;
      sram_cen_q  <= 1'b0;
      sram_a_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (!bus.fifo_empty) begin
            state_q     <= S_POP;
            fifo_rinc_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_POP: begin
          state_q <= S_CAPT;
        end
        S_CAPT: begin
          if (bus.fifo_valid) begin
            base_q     <= desc_base;
            len_q      <= bus.fifo_fv_addr[3:0];
            tag_q      <= bus.fifo_pe_tag;
            cnt_q      <= '0;
            sram_cen_q <= 1'b1;
            sram_a_q   <= desc_base;
            state_q    <= S_RD;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RD: begin
          state_q <= S_RSP;
        end
        S_RSP: begin
          pe_valid_q <= 1'b1;
          pe_data_q  <= bus.sram_d;
          pe_tag_q   <= tag_q;
          pe_last_q  <= (cnt_q == len_q);
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (hs) begin
            pe_valid_q <= 1'b0;
            if (pe_last_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q      <= cnt_nxt;
              sram_cen_q <= 1'b1;
              sram_a_q   <= base_q + AW'(cnt_nxt);
              state_q    <= S_RD;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rinc = fifo_rinc_q;
  assign bus.sram_cen  = sram_cen_q;
  assign bus.sram_a    = sram_a_q;
  assign bus.pe_valid  = pe_valid_q;
  assign bus.pe_data   = pe_data_q;
  assign bus.pe_tag    = pe_tag_q;
  assign bus.pe_last   = pe_last_q;
  assign bus.busy      = busy_q;
  assign dbg_state_o   = state_q;

  // A stalled beat never changes, and SRAM reads never overlap.
  a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
    (pe_valid_q && !hs) |=> (pe_valid_q && $stable(pe_data_q)));
  a_one_read: assert property (@(posedge clk) disable iff (!reset)
    sram_cen_q |=> !sram_cen_q);

endmodule

// File: tb/tb_fv_mem_cntl.sv
// Bench for fv_mem_cntl: FIFO/SRAM/PE models, a beat scoreboard, a descriptor
// vector table and hand-written stall / no-valid / reset / back-to-back cases.
`timescale 1ns/1ps
module tb_fv_mem_cntl;
  import fv_mem_cntl_pkg::*;

  localparam int NPE = 4;
  localparam int FW  = 128;
  localparam int AWD = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  fv_mem_cntl_if #(.NUM_PE(NPE), .FV_W(FW), .AW(AWD)) bus ();

  fv_mem_cntl #(.NUM_PE(NPE), .FV_W(FW), .AW(AWD)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- shared state ----------------
  int             n_cmp = 0;
  int             n_bad = 0;
  fv_desc_t       desc_q[$];
  pe_out_t        exp_q[$];
  logic [AWD-1:0] exp_a_q[$];
  bit             suppress_valid = 1'b0;
  int             rinc_cnt = 0;
  int             cen_cnt = 0;
  int             beat_cnt = 0;
  int             cyc = 0;
  int             last_gap = 0;
  int             last_hs_cyc = 0;
  logic [1:0]     ready_mode = 2'd0;
  logic [3:0]     ready_val = 4'b1111;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mem_line(input logic [7:0] a);
    return {8{a, a ^ 8'hC3}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic [11:0] a, input logic [1:0] t);
    desc_q.push_back('{fv_addr: a, pe_tag: t, valid: 1'b1});
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.pe_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_valid_timeout"}, 1, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(desc_q.size() == 0 && exp_q.size() == 0 && !bus.busy && !bus.fifo_valid)
               && n < 2000);
    if (n >= 2000) chk({name, "_timeout"}, 1, 0);
  endtask

  // FIFO model: data valid the cycle after a sampled pop; expectations pushed here.
  initial begin
    bit         pop_now;
    fv_desc_t   d;
    logic [7:0] a;
    bus.fifo_empty   = 1'b1;
    bus.fifo_valid   = 1'b0;
    bus.fifo_fv_addr = '0;
    bus.fifo_pe_tag  = '0;
    forever begin
      @(negedge clk);
      pop_now = reset && bus.fifo_rinc;
      @(posedge clk);
      #1;
      bus.fifo_valid = 1'b0;
      if (pop_now) begin
        rinc_cnt++;
        chk("pop_only_when_idle", exp_q.size(), 0);
        if (desc_q.size() > 0) begin
          d = desc_q.pop_front();
          if (!suppress_valid) begin
            bus.fifo_valid   = 1'b1;
            bus.fifo_fv_addr = d.fv_addr;
            bus.fifo_pe_tag  = d.pe_tag;
            for (int i = 0; i <= int'(d.fv_addr[3:0]); i++) begin
              a = d.fv_addr[11:4] + 8'(i);
              exp_a_q.push_back(a);
              exp_q.push_back('{valid: 1'b1, tag: d.pe_tag,
                                last: (i == int'(d.fv_addr[3:0])), data: mem_line(a)});
            end
          end
        end
      end
      bus.fifo_empty = (desc_q.size() == 0);
    end
  end

  // SRAM model: data one cycle after the read, junk otherwise.
  initial begin
    bit         cen_s;
    logic [7:0] a_s;
    bus.sram_d = '0;
    forever begin
      @(negedge clk);
      cen_s = bus.sram_cen;
      a_s   = bus.sram_a;
      @(posedge clk);
      #1;
      if (cen_s) bus.sram_d = mem_line(a_s);
      else       bus.sram_d = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // PE ready driver.
  initial begin
    bus.pe_ready = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.pe_ready = (ready_mode == 2'd2) ? 4'($urandom) : ready_val;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    bit             pv_prev = 1'b0;
    bit             rinc_prev = 1'b0;
    logic [FW-1:0]  pd_prev = '0;
    pe_out_t        e;
    logic [AWD-1:0] ea;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        pv_prev   = 1'b0;
        rinc_prev = 1'b0;
      end else begin
        if (bus.sram_cen) begin
          cen_cnt++;
          if (exp_a_q.size() == 0) chk("unexpected_sram_read", 1, 0);
          else begin
            ea = exp_a_q.pop_front();
            chk("sram_a", bus.sram_a, ea);
          end
        end else if (bus.sram_a != '0) chk("sram_a_zero_outside_rd", bus.sram_a, 0);
        if (rinc_prev && bus.fifo_rinc) chk("fifo_rinc_single_pulse", 1, 0);
        rinc_prev = bus.fifo_rinc;
        if (pv_prev) begin
          chk("hold_pe_valid", bus.pe_valid, 1);
          chk("hold_pe_data", bus.pe_data, pd_prev);
        end
        pv_prev = 1'b0;
        if (bus.pe_valid) begin
          if (bus.pe_ready[bus.pe_tag]) begin
            beat_cnt++;
            last_gap    = cyc - last_hs_cyc;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
              e = exp_q.pop_front();
              chk("pe_data", bus.pe_data, e.data);
              chk("pe_tag", bus.pe_tag, e.tag);
              chk("pe_last", bus.pe_last, e.last);
            end
          end else begin
            pv_prev = 1'b1;
            pd_prev = bus.pe_data;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  typedef struct {
    logic [11:0] addr;
    logic [1:0]  tag;
    logic [1:0]  mode;
    logic [3:0]  rdy;
    int          beats;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int            b0, r0, c0, n, lat;
    logic [FW-1:0] held;

    vecs[0] = '{12'h123, 2'd2, 2'd0, 4'b0100, 4};
    vecs[1] = '{12'hFF1, 2'd1, 2'd0, 4'b1111, 2};
    vecs[2] = '{12'h370, 2'd0, 2'd0, 4'b0001, 1};
    vecs[3] = '{12'h08F, 2'd3, 2'd2, 4'b0000, 16};
    vecs[4] = '{12'hA05, 2'd1, 2'd2, 4'b0000, 6};
    vecs[5] = '{12'hFFF, 2'd0, 2'd0, 4'b1111, 16};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fifo_rinc", bus.fifo_rinc, 0);
    chk("rst_sram_cen", bus.sram_cen, 0);
    chk("rst_sram_a", bus.sram_a, 0);
    chk("rst_pe_valid", bus.pe_valid, 0);
    chk("rst_pe_data", bus.pe_data, 0);
    chk("rst_pe_tag", bus.pe_tag, 0);
    chk("rst_pe_last", bus.pe_last, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Minimum latency fifo_empty low -> first pe_valid.
    ready_mode = 2'd0;
    ready_val  = 4'b1111;
    push(12'h600, 2'd0);
    n = 0;
    while (bus.fifo_empty && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    while (!bus.pe_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("first_beat_latency", lat, 5);
    wait_done("latency");

    // Descriptor table.
    foreach (vecs[i]) begin
      b0 = beat_cnt;
      r0 = rinc_cnt;
      ready_mode = vecs[i].mode;
      ready_val  = vecs[i].rdy;
      push(vecs[i].addr, vecs[i].tag);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_beats", i), beat_cnt - b0, vecs[i].beats);
      chk($sformatf("vec%0d_pops", i), rinc_cnt - r0, 1);
      if (vecs[i].mode == 2'd0 && vecs[i].beats > 1)
        chk($sformatf("vec%0d_beat_gap", i), last_gap, 3);
    end

    // Target PE stalled for 10 cycles while the other PEs are ready.
    ready_mode = 2'd0;
    ready_val  = 4'b1101;
    b0 = beat_cnt;
    push(12'h232, 2'd1);
    wait_valid("stall");
    held = bus.pe_data;
    c0   = cen_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("stall_pe_valid", bus.pe_valid, 1);
      chk("stall_pe_data", bus.pe_data, held);
    end
    chk("stall_no_sram_read", cen_cnt - c0, 0);
    @(posedge clk);
    #1 ready_val = 4'b1111;
    wait_done("stall");
    chk("stall_beats", beat_cnt - b0, 3);

    // Pop whose data never arrives.
    suppress_valid = 1'b1;
    b0 = beat_cnt;
    r0 = rinc_cnt;
    c0 = cen_cnt;
    push(12'h777, 2'd2);
    wait_done("novalid");
    chk("novalid_pops", rinc_cnt - r0, 1);
    chk("novalid_sram_reads", cen_cnt - c0, 0);
    chk("novalid_beats", beat_cnt - b0, 0);
    suppress_valid = 1'b0;

    // Reset during HOLD of beat 2 of 3.
    ready_val = 4'b0000;
    push(12'h402, 2'd3);
    wait_valid("rst_beat1");
    @(posedge clk);
    #1 ready_val = 4'b1000;
    @(negedge clk);
    @(posedge clk);
    #1 ready_val = 4'b0000;
    @(negedge clk);
    wait_valid("rst_beat2");
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_a_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", dbg_state, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pe_valid", bus.pe_valid, 0);
    chk("midrst_pe_data", bus.pe_data, 0);
    chk("midrst_pe_last", bus.pe_last, 0);
    chk("midrst_sram_cen", bus.sram_cen, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    ready_val = 4'b1111;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_no_valid", bus.pe_valid, 0);
    end
    b0 = beat_cnt;
    push(12'h501, 2'd3);
    wait_done("postrst");
    chk("postrst_beats", beat_cnt - b0, 2);

    // Back-to-back descriptors.
    b0 = beat_cnt;
    r0 = rinc_cnt;
    push(12'h112, 2'd0);
    push(12'h221, 2'd3);
    wait_done("b2b");
    chk("b2b_pops", rinc_cnt - r0, 2);
    chk("b2b_beats", beat_cnt - b0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
